// File: rtl/imem_port_arbiter_if.sv
// Bundle of signals between the two instruction-memory requesters, the
// shared memory read port and the arbiter. The arbiter uses the slave view;
// the requesters and memory together form the master view.
interface imem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic [AW-1:0] addr1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd;

  modport master (
    output req0, addr0, req1, addr1, mem_rd,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_addr
  );

  modport slave (
    input  req0, addr0, req1, addr1, mem_rd,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_addr
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing the instruction memory read port between the
// fetch stage (requester 0) and the debug/trace reader (requester 1).
// Grant is combinational; the winner's word-aligned address is registered
// onto mem_addr, and the returned word is registered back to the winner one
// cycle later, giving a fixed two-cycle grant-to-rvalid latency.
//
// state     | meaning
// PRIO_REQ0 | requester 0 wins when both request
// PRIO_REQ1 | requester 1 wins when both request
module imem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               reset,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  prio_t         prio;
  prio_t         prio_next;
  logic          gnt0;
  logic          gnt1;
  logic [AW-1:0] grant_addr;

  logic          s1_valid;
  logic          s1_id;
  logic [AW-1:0] mem_addr;

  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  // Favoured-requester register; the loser of a contended cycle is favoured next.
  always_ff @(posedge clk) begin
    if (reset) prio <= PRIO_REQ0;
    else       prio <= prio_next;
  end

  // Grant decision, winning address select and next favoured requester.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    prio_next  = prio;
    grant_addr = bus.addr0;
    if (!reset) begin
      if (bus.req0 && (!bus.req1 || prio == PRIO_REQ0)) gnt0 = 1'b1;
      else if (bus.req1)                                 gnt1 = 1'b1;
    end
    if (gnt0) begin
      prio_next = PRIO_REQ1;
    end else if (gnt1) begin
      prio_next  = PRIO_REQ0;
      grant_addr = bus.addr1;
    end
  end

  // Stage 1: issue the granted address to memory; address holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      mem_addr <= '0;
    end else begin
      s1_valid <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        s1_id    <= gnt1;
        mem_addr <= grant_addr & ALIGN_MASK;
      end
    end
  end

  // Stage 2: capture memory data for the stage-1 owner and strobe its rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= s1_valid & ~s1_id;
      rvalid1 <= s1_valid &  s1_id;
      if (s1_valid && !s1_id) rdata0 <= bus.mem_rd;
      if (s1_valid &&  s1_id) rdata1 <= bus.mem_rd;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.mem_addr = mem_addr;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rdata0   = rdata0;
  assign bus.rdata1   = rdata1;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model (favoured
// requester, queue of pending responses with due cycles, last data per port).
module tb_imem_port_arbiter;

  logic clk;
  logic reset;

  imem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  imem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: word at byte address a is E000_0000 | a[7:0].
  assign bus.mem_rd = 32'hE000_0000 | {24'h0, bus.mem_addr[7:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } resp_t;

  resp_t       resp_q[$];
  int          cyc;
  int          fav;
  logic [31:0] m_addr;
  logic [31:0] m_rdata[2];
  logic [1:0]  exp_rv;

  int n_checks;
  int n_pass;

  int          w;
  logic        h0, h1, r0, r1, rst_r;
  logic [31:0] a0, a1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
  endtask

  task automatic model_reset();
    fav        = 0;
    m_addr     = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    exp_rv     = 2'b00;
    resp_q.delete();
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic q0, input logic [31:0] d0, input logic q1,
                      input logic [31:0] d1, input logic rst, output int win);
    logic [31:0] al;
    resp_t       r;
    reset     = rst;
    bus.req0  = q0;
    bus.addr0 = d0;
    bus.req1  = q1;
    bus.addr1 = d1;
    #2;
    win = -1;
    if (!rst) begin
      if (q0 && (!q1 || fav == 0)) win = 0;
      else if (q1)                 win = 1;
    end
    check("gnt0",     {31'b0, bus.gnt0},    {31'b0, win == 0});
    check("gnt1",     {31'b0, bus.gnt1},    {31'b0, win == 1});
    check("mem_addr", bus.mem_addr,          m_addr);
    check("rvalid0",  {31'b0, bus.rvalid0}, {31'b0, exp_rv[0]});
    check("rvalid1",  {31'b0, bus.rvalid1}, {31'b0, exp_rv[1]});
    check("rdata0",   bus.rdata0,            m_rdata[0]);
    check("rdata1",   bus.rdata1,            m_rdata[1]);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (win >= 0) begin
      al     = (win == 0 ? d0 : d1) & 32'hFFFF_FFFC;
      m_addr = al;
      fav    = 1 - win;
      resp_q.push_back('{due: cyc + 2, id: win, data: 32'hE000_0000 | {24'h0, al[7:0]}});
    end
    cyc++;
    exp_rv = 2'b00;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      exp_rv[r.id]   = 1'b1;
      m_rdata[r.id]  = r.data;
    end
  endtask

  task automatic idle(input int n);
    int wd;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, wd);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    reset     = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with both requesting, then release with both requesting.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b1, 32'h50, 1'b1, w);
    // Contention: six cycles of both requesting, grants alternate 0,1,...
    for (int i = 0; i < 6; i++) step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, w);
    idle(3);

    // Single requester stream.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, w);
    idle(3);

    // Unaligned address.
    step(1'b0, 32'h0, 1'b1, 32'h0000_0007, 1'b0, w);
    idle(3);

    // Reset while an access is in flight; prio must return to requester 0.
    step(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, w);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, w);
    idle(3);
    step(1'b1, 32'h14, 1'b1, 32'h24, 1'b0, w);
    idle(2);

    // Single grant then idle gap; data and address hold.
    step(1'b0, 32'h0, 1'b1, 32'h30, 1'b0, w);
    idle(4);

    // Random traffic honouring hold-until-granted, with occasional resets.
    h0 = 1'b0;
    h1 = 1'b0;
    r0 = 1'b0;
    r1 = 1'b0;
    a0 = '0;
    a1 = '0;
    for (int i = 0; i < 400; i++) begin
      rst_r = ($urandom_range(0, 39) == 0);
      if (!h0) begin
        r0 = 1'($urandom_range(0, 1));
        a0 = $urandom;
      end
      if (!h1) begin
        r1 = 1'($urandom_range(0, 1));
        a1 = $urandom;
      end
      step(r0, a0, r1, a1, rst_r, w);
      h0 = r0 && (w != 0) && !rst_r;
      h1 = r1 && (w != 1) && !rst_r;
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
